// File: rtl/etapa_mem.sv
// Memory-access stage of the five-stage MIPS pipeline: a multi-cycle data memory behind a
// LIBRE/ACCESO/LISTO controller that stalls upstream while an access is in flight.
module etapa_mem #(
    parameter int PALABRAS = 256,
    parameter int LATENCIA = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_leer_ent,
    input  logic        mem_escribir_ent,
    input  logic [1:0]  tamano_ent,
    input  logic        sin_signo_ent,
    input  logic [31:0] direccion_ent,
    input  logic [31:0] dato_escribir_ent,
    input  logic        reg_escribir_ent,
    input  logic        mem_a_reg_ent,
    input  logic [4:0]  registro_destino_ent,
    output logic        reg_escribir_MEM,
    output logic        mem_a_reg_MEM,
    output logic [31:0] dato_memoria_MEM,
    output logic [31:0] resultado_alu_MEM,
    output logic [4:0]  registro_destino_MEM,
    output logic        detener,
    output logic        error_alineacion
);

    localparam int IW = $clog2(PALABRAS);
    localparam logic [3:0] CUENTA_INI = 4'(LATENCIA - 1);

    typedef enum logic [1:0] {LIBRE, ACCESO, LISTO} estado_t;

    estado_t     estado, estado_sig;
    logic [3:0]  cuenta;
    logic [31:0] mem [PALABRAS];

    logic        lat_escribir, lat_sin_signo, lat_reg_escribir, lat_mem_a_reg;
    logic [1:0]  lat_tamano;
    logic [31:0] lat_dir, lat_dato, palabra_leida, extraido, dato_lanes;
    logic [4:0]  lat_destino;
    logic [3:0]  habilita;
    logic [7:0]  byte_sel;
    logic [15:0] media_sel;

    logic op_mem, desalineado, inicia, ultimo_ciclo;
    logic [IW-1:0] lat_idx;

    assign op_mem       = mem_leer_ent | mem_escribir_ent;
    assign desalineado  = (tamano_ent == 2'b01 && direccion_ent[0]) ||
                          (tamano_ent[1] && direccion_ent[1:0] != 2'b00);
    assign inicia       = (estado == LIBRE) && op_mem && !desalineado;
    assign ultimo_ciclo = reset && (estado == ACCESO) && (cuenta == 4'd0);
    assign lat_idx      = lat_dir[IW+1:2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado <= LIBRE;
            cuenta <= 4'd0;
        end else begin
            estado <= estado_sig;
            if (inicia)
                cuenta <= CUENTA_INI;
            else if (estado == ACCESO && cuenta != 4'd0)
                cuenta <= cuenta - 4'd1;
        end
    end

    // Instruction latches; only consumed in ACCESO/LISTO, so they need no reset value.
    always_ff @(posedge clk) begin
        if (inicia) begin
            lat_escribir     <= mem_escribir_ent;
            lat_tamano       <= tamano_ent;
            lat_sin_signo    <= sin_signo_ent;
            lat_dir          <= direccion_ent;
            lat_dato         <= dato_escribir_ent;
            lat_reg_escribir <= reg_escribir_ent;
            lat_mem_a_reg    <= mem_a_reg_ent;
            lat_destino      <= registro_destino_ent;
        end
        if (ultimo_ciclo && !lat_escribir)
            palabra_leida <= mem[lat_idx];
    end

    always_comb begin
        habilita   = 4'b1111;
        dato_lanes = lat_dato;
        case (lat_tamano)
            2'b00: begin
                habilita   = 4'b0001 << lat_dir[1:0];
                dato_lanes = {4{lat_dato[7:0]}};
            end
            2'b01: begin
                habilita   = lat_dir[1] ? 4'b1100 : 4'b0011;
                dato_lanes = {2{lat_dato[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: the array is deliberately left out of reset; a reset port would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (ultimo_ciclo && lat_escribir) begin
            for (int b = 0; b < 4; b++)
                if (habilita[b]) mem[lat_idx][8*b +: 8] <= dato_lanes[8*b +: 8];
        end
    end

    always_comb begin
        byte_sel  = palabra_leida[{lat_dir[1:0], 3'b000} +: 8];
        media_sel = lat_dir[1] ? palabra_leida[31:16] : palabra_leida[15:0];
        case (lat_tamano)
            2'b00:   extraido = lat_sin_signo ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   extraido = lat_sin_signo ? {16'b0, media_sel} : {{16{media_sel[15]}}, media_sel};
            default: extraido = palabra_leida;
        endcase
    end

    always_comb begin
        estado_sig           = estado;
        detener              = 1'b0;
        error_alineacion     = 1'b0;
        reg_escribir_MEM     = 1'b0;
        mem_a_reg_MEM        = 1'b0;
        dato_memoria_MEM     = 32'b0;
        resultado_alu_MEM    = 32'b0;
        registro_destino_MEM = 5'b0;
        case (estado)
            LIBRE: begin
                if (!op_mem) begin
                    reg_escribir_MEM     = reg_escribir_ent;
                    mem_a_reg_MEM        = mem_a_reg_ent;
                    resultado_alu_MEM    = direccion_ent;
                    registro_destino_MEM = registro_destino_ent;
                end else if (desalineado) begin
                    error_alineacion = 1'b1;
                end else begin
                    detener    = 1'b1;
                    estado_sig = ACCESO;
                end
            end
            ACCESO: begin
                detener = 1'b1;
                if (cuenta == 4'd0) estado_sig = LISTO;
            end
            LISTO: begin
                reg_escribir_MEM     = lat_reg_escribir;
                mem_a_reg_MEM        = lat_mem_a_reg;
                dato_memoria_MEM     = lat_escribir ? 32'b0 : extraido;
                resultado_alu_MEM    = lat_dir;
                registro_destino_MEM = lat_destino;
                estado_sig           = LIBRE;
            end
            default: estado_sig = LIBRE;
        endcase
        if (!reset) begin
            detener              = 1'b0;
            error_alineacion     = 1'b0;
            reg_escribir_MEM     = 1'b0;
            mem_a_reg_MEM        = 1'b0;
            dato_memoria_MEM     = 32'b0;
            resultado_alu_MEM    = 32'b0;
            registro_destino_MEM = 5'b0;
        end
    end

endmodule

// File: tb/tb_etapa_mem.sv
// Directed bench for etapa_mem (PALABRAS=256, LATENCIA=2): stall timing, lane handling,
// misalignment, reset abort and address aliasing.
module tb_etapa_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_leer_ent, mem_escribir_ent, sin_signo_ent;
    logic [1:0]  tamano_ent;
    logic [31:0] direccion_ent, dato_escribir_ent;
    logic        reg_escribir_ent, mem_a_reg_ent;
    logic [4:0]  registro_destino_ent;
    logic        reg_escribir_MEM, mem_a_reg_MEM, detener, error_alineacion;
    logic [31:0] dato_memoria_MEM, resultado_alu_MEM;
    logic [4:0]  registro_destino_MEM;

    int n_checks = 0;
    int n_fail   = 0;

    etapa_mem #(.PALABRAS(256), .LATENCIA(2)) dut (
        .clk(clk), .reset(reset),
        .mem_leer_ent(mem_leer_ent), .mem_escribir_ent(mem_escribir_ent),
        .tamano_ent(tamano_ent), .sin_signo_ent(sin_signo_ent),
        .direccion_ent(direccion_ent), .dato_escribir_ent(dato_escribir_ent),
        .reg_escribir_ent(reg_escribir_ent), .mem_a_reg_ent(mem_a_reg_ent),
        .registro_destino_ent(registro_destino_ent),
        .reg_escribir_MEM(reg_escribir_MEM), .mem_a_reg_MEM(mem_a_reg_MEM),
        .dato_memoria_MEM(dato_memoria_MEM), .resultado_alu_MEM(resultado_alu_MEM),
        .registro_destino_MEM(registro_destino_MEM),
        .detener(detener), .error_alineacion(error_alineacion)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] salidas_or();
        return dato_memoria_MEM | resultado_alu_MEM |
               {25'b0, reg_escribir_MEM, mem_a_reg_MEM, registro_destino_MEM} |
               {30'b0, detener, error_alineacion};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic siguiente();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [31:0] dir, input logic [4:0] dest);
        mem_leer_ent = 0; mem_escribir_ent = 0; tamano_ent = 2'b10; sin_signo_ent = 0;
        direccion_ent = dir; dato_escribir_ent = 32'h0;
        reg_escribir_ent = 1; mem_a_reg_ent = 0; registro_destino_ent = dest;
    endtask

    task automatic poner_op(input logic leer, input logic escribir, input logic [1:0] tam,
                            input logic sin, input logic [31:0] dir, input logic [31:0] dato);
        mem_leer_ent = leer; mem_escribir_ent = escribir; tamano_ent = tam; sin_signo_ent = sin;
        direccion_ent = dir; dato_escribir_ent = dato;
        reg_escribir_ent = leer & ~escribir; mem_a_reg_ent = leer & ~escribir;
        registro_destino_ent = 5'd9;
    endtask

    // Full memory op: three stalled bubble cycles, then the result in LISTO.
    task automatic mem_op(input string tag, input logic leer, input logic escribir,
                          input logic [1:0] tam, input logic sin, input logic [31:0] dir,
                          input logic [31:0] dato, input logic [31:0] esperado);
        logic carga;
        carga = leer & ~escribir;
        poner_op(leer, escribir, tam, sin, dir, dato);
        for (int c = 0; c < 3; c++) begin
            #2;
            check({tag, "_det"}, {31'b0, detener}, 32'd1);
            check({tag, "_bub"}, salidas_or() & ~32'd2, 32'd0);
            siguiente();
        end
        #2;
        check({tag, "_det_listo"}, {31'b0, detener}, 32'd0);
        check({tag, "_dato"}, dato_memoria_MEM, esperado);
        check({tag, "_alu"}, resultado_alu_MEM, dir);
        check({tag, "_ctl"}, {30'b0, reg_escribir_MEM, mem_a_reg_MEM}, {30'b0, carga, carga});
        check({tag, "_dest"}, {27'b0, registro_destino_MEM}, 32'd9);
        siguiente();
        nop(32'h0, 5'd0);
    endtask

    initial begin
        reset = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            {mem_leer_ent, mem_escribir_ent, tamano_ent, sin_signo_ent} = 5'($urandom);
            direccion_ent = $urandom; dato_escribir_ent = $urandom;
            {reg_escribir_ent, mem_a_reg_ent, registro_destino_ent} = 7'($urandom);
            #2;
            check("reset_salidas", salidas_or(), 32'd0);
            siguiente();
        end

        reset = 1;
        nop(32'h10, 5'd5);
        mem_a_reg_ent = 0;
        #2;
        check("pass_det", {31'b0, detener}, 32'd0);
        check("pass_regw", {31'b0, reg_escribir_MEM}, 32'd1);
        check("pass_alu", resultado_alu_MEM, 32'h10);
        check("pass_dest", {27'b0, registro_destino_MEM}, 32'd5);
        check("pass_dato", dato_memoria_MEM, 32'd0);
        siguiente();

        mem_op("sw40", 0, 1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h0);
        mem_op("lw40", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hDEADBEEF);
        mem_op("sb41", 0, 1, 2'b00, 0, 32'h41, 32'hAAAAAA80, 32'h0);
        mem_op("lb41", 1, 0, 2'b00, 0, 32'h41, 32'h0, 32'hFFFFFF80);
        mem_op("lbu41", 1, 0, 2'b00, 1, 32'h41, 32'h0, 32'h00000080);
        mem_op("lw40b", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hDEAD80EF);

        // Misaligned accesses: one-cycle error, no stall, bubble, no write.
        poner_op(1, 0, 2'b01, 0, 32'h43, 32'h0);
        #2;
        check("lh43_err", {31'b0, error_alineacion}, 32'd1);
        check("lh43_det", {31'b0, detener}, 32'd0);
        check("lh43_regw", {31'b0, reg_escribir_MEM}, 32'd0);
        siguiente();
        poner_op(0, 1, 2'b10, 0, 32'h42, 32'h11111111);
        #2;
        check("sw42_err", {31'b0, error_alineacion}, 32'd1);
        check("sw42_det", {31'b0, detener}, 32'd0);
        siguiente();
        nop(32'h20, 5'd3);
        #2;
        check("post_err", {31'b0, error_alineacion}, 32'd0);
        check("post_alu", resultado_alu_MEM, 32'h20);
        siguiente();
        mem_op("lw40c", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hDEAD80EF);

        // Store aborted by reset during its first ACCESO cycle.
        mem_op("sw80", 0, 1, 2'b10, 0, 32'h80, 32'h0BADF00D, 32'h0);
        poner_op(0, 1, 2'b10, 0, 32'h80, 32'h12345678);
        #2;
        check("abort_det1", {31'b0, detener}, 32'd1);
        siguiente();
        reset = 0;
        #2;
        check("abort_rst", salidas_or(), 32'd0);
        siguiente();
        reset = 1;
        nop(32'h30, 5'd6);
        #2;
        check("abort_libre_det", {31'b0, detener}, 32'd0);
        check("abort_libre_alu", resultado_alu_MEM, 32'h30);
        check("abort_libre_dest", {27'b0, registro_destino_MEM}, 32'd6);
        siguiente();
        mem_op("lw80", 1, 0, 2'b10, 0, 32'h80, 32'h0, 32'h0BADF00D);

        // Aliasing modulo 4*PALABRAS bytes.
        mem_op("lw440", 1, 0, 2'b10, 0, 32'h440, 32'h0, 32'hDEAD80EF);

        // Half-word lane and both-strobes-high store.
        mem_op("sh42", 0, 1, 2'b01, 0, 32'h42, 32'h5555CAFE, 32'h0);
        mem_op("lh42", 1, 0, 2'b01, 0, 32'h42, 32'h0, 32'hFFFFCAFE);
        mem_op("lhu42", 1, 0, 2'b01, 1, 32'h42, 32'h0, 32'h0000CAFE);
        mem_op("lw40d", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFE80EF);
        mem_op("both84", 1, 1, 2'b11, 0, 32'h84, 32'h00000055, 32'h0);
        mem_op("lw84", 1, 0, 2'b11, 0, 32'h84, 32'h0, 32'h00000055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/etapa_mem.md
# etapa_mem

Memory-access stage of the five-stage MIPS pipeline. It sits between the EX/MEM pipeline buffer and the MEM/WB buffer. It performs loads and stores against an internal data memory with a fixed multi-cycle access latency, and stalls the upstream pipeline while an access is in flight. It presents the completed instruction (control, loaded data, ALU result, destination register) on the inputs of the MEM/WB buffer.

## Interface
- PALABRAS, 256, data-memory depth in 32-bit words (power of two, ≥4)
- LATENCIA, 2, wait cycles per memory access (1..15)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk)
- mem_leer_ent  input  1  load request
- mem_escribir_ent  input  1  store request
- tamano_ent  input  2  access size: 00 byte, 01 half, 10/11 word
- sin_signo_ent  input  1  1 = zero-extend sub-word loads, 0 = sign-extend
- direccion_ent  input  32  byte address (ALU result)
- dato_escribir_ent  input  32  store data (rt)
- reg_escribir_ent, mem_a_reg_ent  input  1 each  WB control from EX/MEM
- registro_destino_ent  input  5  destination register
- reg_escribir_MEM, mem_a_reg_MEM  output  1 each  control to MEM/WB
- dato_memoria_MEM  output  32  load result
- resultado_alu_MEM  output  32  ALU result passthrough
- registro_destino_MEM  output  5  destination passthrough
- detener  output  1  stall request to hazard unit (freeze PC and IF..EX/MEM buffers)
- error_alineacion  output  1  misaligned access indication

## Operation
- FSM states: LIBRE, ACCESO, LISTO. Reset state is LIBRE. 4-bit down-counter `cuenta`.
- **LIBRE, no memory op.** All outputs follow the inputs combinationally. dato_memoria_MEM = 0. detener = 0.
- **LIBRE, aligned memory op.**
  - Latch all inputs.
  - cuenta ← LATENCIA-1; go to ACCESO.
  - detener = 1 in this cycle.
  - Outputs are a bubble: all outputs 0.
- **ACCESO.**
  - detener = 1; outputs are a bubble.
  - Decrement cuenta. At cuenta = 0, go to LISTO.
  - On that same edge: a store writes the array; a load captures the read word.
- **LISTO.**
  - detener = 0.
  - Outputs present the latched instruction:
    - reg_escribir_MEM and mem_a_reg_MEM from the latches;
    - dato_memoria_MEM = extracted load data (0 for stores).
  - Next state is LIBRE.
  - The upstream buffer advances at the end of this cycle.
- **Misalignment.** Half access with addr[0]=1, or word access with addr[1:0]≠0.
  - No stall and no write.
  - error_alineacion = 1 for that LIBRE cycle.
  - Outputs are a bubble.
- **Both leer and escribir high.** Treated as a store; dato_memoria_MEM = 0.
- **Word index.** addr[log2(PALABRAS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·PALABRAS.
- **Byte lanes are little-endian.**
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Stores write only the addressed lanes; other lanes keep their contents.
  - Loads extract the lane, then sign- or zero-extend per sin_signo_ent.
- **Memory array.** Not cleared by reset; contents are undefined until written.

## Timing
- **Reset.** While reset = 0 at an edge:
  - FSM → LIBRE; cuenta → 0.
  - All outputs are forced to 0 combinationally while reset is low: detener, error_alineacion, reg_escribir_MEM, mem_a_reg_MEM, dato_memoria_MEM, resultado_alu_MEM, registro_destino_MEM.
- **Reset mid-operation.**
  - In-flight access is abandoned.
  - A store whose write edge has not yet occurred is dropped.
  - Loaded data is discarded.
- **Memory op timing.**
  - Occupies LATENCIA+2 cycles in the stage.
  - detener is high for LATENCIA+1 consecutive cycles.
  - Result is valid in the following (LISTO) cycle.
  - With LATENCIA=2: detener high for 3 cycles; result on cycle 4.
- **Non-memory instruction.** Zero added latency.
- **Back-to-back memory ops.** LISTO → LIBRE; the next op raises detener again in its first LIBRE cycle. There is never a cycle with both detener = 1 and a non-bubble output.
- **Upstream hold.** Inputs must be held stable while detener = 1 (upstream frozen). The block nevertheless uses only its latched copies after LIBRE.
- **Store-then-load, same address.** The load observes the stored value.

## Test plan
- Reset low 2 cycles with random inputs -> all outputs 0. Release with a non-memory op (reg_escribir_ent=1, direccion_ent=0x10, registro_destino_ent=5) -> same-cycle passthrough, detener=0.
- Store word 0xDEADBEEF at 0x40, then load word 0x40 (LATENCIA=2) -> each op gives detener high 3 cycles with bubble outputs, then dato_memoria_MEM=0xDEADBEEF.
- Store byte 0x80 at 0x41, then load byte signed 0x41 -> 0xFFFFFF80. Load unsigned 0x41 -> 0x00000080. Load word 0x40 -> 0xDEAD80EF.
- Load half at 0x43 -> error_alineacion=1 for one cycle, detener=0, reg_escribir_MEM=0, memory unchanged.
- Store word 0x12345678 at 0x80, asserting reset during the first ACCESO cycle -> outputs 0, state LIBRE. A subsequent load word 0x80 returns the prior contents.
- Address 0x40 + 4·PALABRAS -> aliases to the word at 0x40.
